mdu_iterative: RTL and testbench
================================

// Module: mdu_iterative
// PURPOSE
//  Parametrised iterative multiply/divide unit for the pipelined MIPS core's execute stage.
//  Implements MULT/MULTU/DIV/DIVU into architectural HI/LO registers, plus MTHI/MTLO.
//  Radix-2 shift-add multiply and restoring divide, one bit per cycle.
//  The decode stage stalls on op_ready=0 and reads hi/lo for MFHI/MFLO.
// PARAMETERS
//  XLEN  32  operand/HI/LO width; any value >= 2
// PORTS
//  clock     in   1     rising-edge clock
//  start     in   1     synchronous active-high reset
//  op_valid  in   1     request present this cycle
//  op_ready  out  1     unit can accept; comb. = (state==IDLE) & ~start
//  op_code   in   3     000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//  op_a      in   XLEN  rs operand (dividend / multiplicand / MT source)
//  op_b      in   XLEN  rt operand (divisor / multiplier)
//  flush     in   1     abort in-flight op (branch/jump squash)
//  busy      out  1     registered, = (state != IDLE)
//  done      out  1     one-cycle pulse: hi/lo updated
//  div_zero  out  1     one-cycle pulse with done: DIV/DIVU had op_b==0
//  hi        out  XLEN  HI register
//  lo        out  XLEN  LO register
// BEHAVIOUR
//  Reset (start=1 at an edge): state IDLE, hi=lo=0, busy=done=div_zero=0, counter=0.
//   Reset mid-op aborts it with no done. op_ready=0 while start is high.
//  Accept = op_valid & op_ready & ~flush at a rising edge (edge T).
//  FSM IDLE -> RUN -> FIX -> IDLE:
//   IDLE: on accepted MULT/MULTU/DIV/DIVU, latch |op_a| and |op_b|.
//     Signed ops use 2's-complement magnitude; unsigned ops use raw values.
//     Latch result signs and op kind; clear counter; go RUN.
//   RUN: one iteration per edge, edges T+1..T+XLEN. Counter 0..XLEN-1; at XLEN-1 go FIX.
//   FIX (edge T+XLEN+1): apply sign correction, write hi/lo, pulse done, go IDLE.
//  Latency: done=1 and new hi/lo visible in the cycle after edge T+XLEN+1 (33 for XLEN=32).
//   op_ready is already 1 in the done cycle, so back-to-back ops are allowed.
//  MTHI/MTLO: at edge T write hi (or lo) = op_a and pulse done next cycle.
//   FSM stays in IDLE and div_zero stays 0.
//  Codes 110/111: accepted and ignored; no state change, no done.
//  Multiply: 2*XLEN-bit product {hi,lo}.
//   Signed product negated iff sign(a)^sign(b).
//  Divide: lo = quotient, hi = remainder.
//   Signed: quotient negated iff sign(a)^sign(b); remainder takes sign(a).
//   Most-negative / -1: lo = 1<<(XLEN-1), hi = 0 (wrap, no flag).
//  Divide by zero: same full latency; lo = all ones, hi = op_a as latched.
//   Sign fix-up is skipped; div_zero pulses with done.
//  op_valid while busy: not accepted; requester holds op_valid/operands until op_ready.
//  flush: in RUN/FIX, next edge returns to IDLE; hi/lo unchanged; no done.
//   flush in IDLE blocks acceptance that cycle. flush has priority over FIX writeback.
//  start has priority over flush; flush has priority over accept.
//  Inputs are sampled only at accept; later changes to op_a/op_b are ignored.
// TESTING (XLEN=32)
//  1. MULT a=0xFFFFFFFE, b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//     done exactly 33 cycles after accept; busy 1 for 32+1 cycles.
//  2. MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//     MTLO 0x1234 in the done cycle -> lo=0x1234 one cycle later.
//  3. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1.
//  4. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
//     DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, div_zero=1 with done.
//  5. MULT started, flush at RUN cycle 10 -> no done, hi/lo keep prior values.
//     op_ready=1 next cycle; op_valid held high during busy is accepted only after.
//  6. start asserted mid-DIV (cycle 20) -> hi=lo=0, busy=0, no done.
//     A DIVU issued after reset completes normally.

Source files
------------

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit for the execute stage.
// MULT/MULTU use radix-2 shift-add and DIV/DIVU use restoring division,
// one bit per clock. Both run on magnitudes, and the FIX state applies the
// sign correction. MTHI/MTLO write HI/LO directly from IDLE.
module mdu_iterative #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            start,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [2:0]      op_code,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic            div_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic              done_q, done_d, dz_out_q, dz_out_d;

    // Working registers: rem = product upper half / partial remainder,
    // quo = multiplier / dividend shifting into the quotient,
    // dvs = multiplicand / divisor magnitude.
    logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic              is_div_q, is_div_d, qneg_q, qneg_d, rneg_q, rneg_d;
    logic              dzero_q, dzero_d;

    logic              accept, op_signed, sa, sb;
    logic [XLEN-1:0]   mul_add;
    logic [XLEN:0]     mul_sum, div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_sub;
    logic [2*XLEN-1:0] prod, prod_fix;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    assign op_ready = (state_q == S_IDLE) & ~start;
    assign accept   = op_valid & op_ready & ~flush;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign div_zero = dz_out_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

    // Next-state, iteration datapath and writeback
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dz_out_d  = 1'b0;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        is_div_d  = is_div_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        dzero_d   = dzero_q;

        op_signed = ~op_code[0];
        sa        = op_signed & op_a[XLEN-1];
        sb        = op_signed & op_b[XLEN-1];

        mul_add   = quo_q[0] ? dvs_q : '0;
        mul_sum   = {1'b0, rem_q} + {1'b0, mul_add};
        div_shift = {rem_q, quo_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, dvs_q});
        div_sub   = div_shift[XLEN-1:0] - dvs_q;
        prod      = {rem_q, quo_q};
        prod_fix  = cond_neg2(prod, qneg_q);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op_code)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            is_div_d = op_code[1];
                            if (op_code[1]) begin
                                quo_d = cond_neg(op_a, sa);
                                dvs_d = cond_neg(op_b, sb);
                            end else begin
                                dvs_d = cond_neg(op_a, sa);
                                quo_d = cond_neg(op_b, sb);
                            end
                            rem_d   = '0;
                            qneg_d  = sa ^ sb;
                            rneg_d  = sa;
                            dzero_d = op_code[1] & (op_b == '0);
                            cnt_d   = '0;
                            state_d = S_RUN;
                        end
                        3'b100: begin
                            hi_d   = op_a;
                            done_d = 1'b1;
                        end
                        3'b101: begin
                            lo_d   = op_a;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        rem_d = div_ge ? div_sub : div_shift[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], div_ge};
                    end else begin
                        rem_d = mul_sum[XLEN:1];
                        quo_d = {mul_sum[0], quo_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    if (!is_div_q) begin
                        hi_d = prod_fix[2*XLEN-1:XLEN];
                        lo_d = prod_fix[XLEN-1:0];
                    end else if (dzero_q) begin
                        hi_d = rem_q;
                        lo_d = quo_q;
                    end else begin
                        hi_d = cond_neg(rem_q, rneg_q);
                        lo_d = cond_neg(quo_q, qneg_q);
                    end
                    done_d   = 1'b1;
                    dz_out_d = is_div_q & dzero_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and architectural HI/LO, cleared by start
    always_ff @(posedge clock) begin
        if (start) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_out_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_out_q <= dz_out_d;
        end
    end

    // Working registers; only meaningful while RUN/FIX
    always_ff @(posedge clock) begin
        rem_q    <= rem_d;
        quo_q    <= quo_d;
        dvs_q    <= dvs_d;
        is_div_q <= is_div_d;
        qneg_q   <= qneg_d;
        rneg_q   <= rneg_d;
        dzero_q  <= dzero_d;
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed scoreboard bench for mdu_iterative (XLEN=32).
module tb_mdu_iterative;

    localparam int XLEN = 32;

    logic            clock = 1'b0;
    logic            start, op_valid, flush;
    logic [2:0]      op_code;
    logic [XLEN-1:0] op_a, op_b;
    logic            op_ready, busy, done, div_zero;
    logic [XLEN-1:0] hi, lo;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_hi, m_lo;
    int          n_cmp, n_fail;
    int          lat, bcnt;

    mdu_iterative #(.XLEN(XLEN)) dut (
        .clock    (clock),
        .start    (start),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .op_a     (op_a),
        .op_b     (op_b),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference results computed with native wide arithmetic
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t               r;
        logic signed [63:0] xa, xb, sp;
        logic [63:0]        up;
        logic signed [31:0] sa, sbv, sq, sr;
        r = '{hi: m_hi, lo: m_lo, dz: 1'b0};
        case (op)
            3'd0: begin
                xa = {{32{a[31]}}, a};
                xb = {{32{b[31]}}, b};
                sp = xa * xb;
                r.hi = sp[63:32];
                r.lo = sp[31:0];
            end
            3'd1: begin
                up = {32'b0, a} * {32'b0, b};
                r.hi = up[63:32];
                r.lo = up[31:0];
            end
            3'd2: begin
                sa = a;
                sbv = b;
                if (b == 32'd0) begin
                    r.lo = 32'hFFFF_FFFF;
                    r.hi = a[31] ? -a : a;
                    r.dz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r.lo = 32'h8000_0000;
                    r.hi = 32'd0;
                end else begin
                    sq = sa / sbv;
                    sr = sa % sbv;
                    r.lo = sq;
                    r.hi = sr;
                end
            end
            3'd3: begin
                if (b == 32'd0) begin
                    r.lo = 32'hFFFF_FFFF;
                    r.hi = a;
                    r.dz = 1'b1;
                end else begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
            3'd4: r.hi = a;
            3'd5: r.lo = a;
            default: ;
        endcase
        return r;
    endfunction

    // Present an op, wait for acceptance, then scramble the operand inputs
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit track);
        int   k;
        exp_t e;
        k = 0;
        op_code  = op;
        op_a     = a;
        op_b     = b;
        op_valid = 1'b1;
        while (!op_ready && k < 200) begin
            @(posedge clock); #1;
            k++;
        end
        chk("ready_wait", op_ready, 1);
        @(posedge clock); #1;
        op_valid = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        if (track) begin
            e = model(op, a, b);
            sb_q.push_back(e);
            m_hi = e.hi;
            m_lo = e.lo;
        end
    endtask

    // Wait (bounded) for done, count edges and busy samples, compare with scoreboard
    task automatic wait_done(output int n, output int bc);
        exp_t e;
        n  = 0;
        bc = busy ? 1 : 0;
        while (!done && n < 100) begin
            @(posedge clock); #1;
            n++;
            if (busy) bc++;
        end
        chk("done_seen", done, 1);
        chk("sb_nonempty", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("hi", hi, e.hi);
            chk("lo", lo, e.lo);
            chk("div_zero", div_zero, e.dz);
        end
    endtask

    task automatic no_done(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock); #1;
            if (done) seen = 1'b1;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        m_hi = '0;
        m_lo = '0;
        start = 1'b1;
        op_valid = 1'b0;
        flush = 1'b0;
        op_code = '0;
        op_a = '0;
        op_b = '0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready_low", op_ready, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", div_zero, 0);
        start = 1'b0;
        #1;
        chk("ready_after_rst", op_ready, 1);

        // MULT -2 * 3: latency and busy length
        issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1);
        wait_done(lat, bcnt);
        chk("t1_latency", lat, 33);
        chk("t1_busy_cycles", bcnt, 33);
        chk("t1_hi_const", hi, 32'hFFFF_FFFF);
        chk("t1_lo_const", lo, 32'hFFFF_FFFA);
        @(posedge clock); #1;
        chk("t1_done_pulse", done, 0);

        // MULTU max*max, then MTLO issued in the done cycle
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        wait_done(lat, bcnt);
        chk("t2_hi_const", hi, 32'hFFFF_FFFE);
        chk("t2_lo_const", lo, 32'h0000_0001);
        chk("t2_ready_in_done", op_ready, 1);
        issue(3'd5, 32'h0000_1234, 32'd0, 1);
        wait_done(lat, bcnt);
        chk("t2_mtlo_latency", lat, 0);
        chk("t2_mtlo_lo", lo, 32'h0000_1234);
        chk("t2_mtlo_hi_kept", hi, 32'hFFFF_FFFE);

        // MTHI
        issue(3'd4, 32'hCAFE_F00D, 32'd0, 1);
        wait_done(lat, bcnt);

        // DIV -7/2 and DIVU 7/2
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1);
        wait_done(lat, bcnt);
        chk("t3_div_lo", lo, 32'hFFFF_FFFD);
        chk("t3_div_hi", hi, 32'hFFFF_FFFF);
        issue(3'd3, 32'd7, 32'd2, 1);
        wait_done(lat, bcnt);
        chk("t3_divu_lo", lo, 32'd3);
        chk("t3_divu_hi", hi, 32'd1);

        // Overflow case and divide by zero
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        wait_done(lat, bcnt);
        chk("t4_ovf_lo", lo, 32'h8000_0000);
        chk("t4_ovf_hi", hi, 32'd0);
        issue(3'd3, 32'd5, 32'd0, 1);
        wait_done(lat, bcnt);
        chk("t4_dz_latency", lat, 33);
        chk("t4_dz_lo", lo, 32'hFFFF_FFFF);
        chk("t4_dz_hi", hi, 32'd5);
        chk("t4_dz_flag", div_zero, 1);

        // A few mixed-sign operand patterns
        for (int i = 0; i < 8; i++) begin
            issue(3'(i % 4), $urandom, $urandom | 32'd1, 1);
            wait_done(lat, bcnt);
            chk("rand_latency", lat, 33);
        end

        // Reserved opcode: accepted, ignored
        issue(3'd6, 32'h1111_1111, 32'h2222_2222, 0);
        chk("rsv_busy", busy, 0);
        no_done("rsv_no_done", 3);
        chk("rsv_hi", hi, m_hi);
        chk("rsv_lo", lo, m_lo);

        // flush in IDLE blocks acceptance
        op_code = 3'd0;
        op_a = 32'd9;
        op_b = 32'd9;
        op_valid = 1'b1;
        flush = 1'b1;
        @(posedge clock); #1;
        op_valid = 1'b0;
        flush = 1'b0;
        chk("idle_flush_busy", busy, 0);
        no_done("idle_flush_no_done", 40);

        // flush during RUN
        issue(3'd0, 32'd12345, 32'd678, 0);
        repeat (10) begin
            @(posedge clock); #1;
        end
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        chk("t5_busy_after_flush", busy, 0);
        chk("t5_ready_after_flush", op_ready, 1);
        no_done("t5_no_done", 40);
        chk("t5_hi_kept", hi, m_hi);
        chk("t5_lo_kept", lo, m_lo);

        // op_valid held while busy is taken only after done
        issue(3'd1, 32'h0001_0000, 32'h0003_0000, 1);
        op_code = 3'd3;
        op_a = 32'd1000;
        op_b = 32'd7;
        op_valid = 1'b1;
        sb_q.push_back(model(3'd3, 32'd1000, 32'd7));
        wait_done(lat, bcnt);
        chk("t5_first_latency", lat, 33);
        @(posedge clock); #1;
        op_valid = 1'b0;
        wait_done(lat, bcnt);
        chk("t5_held_latency", lat, 33);
        chk("t5_held_lo", lo, 32'd142);

        // start mid-DIV
        issue(3'd2, 32'd1000, 32'hFFFF_FFFD, 0);
        repeat (20) begin
            @(posedge clock); #1;
        end
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        m_hi = '0;
        m_lo = '0;
        chk("t6_hi", hi, 0);
        chk("t6_lo", lo, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        no_done("t6_no_done", 40);
        issue(3'd3, 32'd100, 32'd7, 1);
        wait_done(lat, bcnt);
        chk("t6_after_latency", lat, 33);
        chk("t6_after_lo", lo, 32'd14);
        chk("t6_after_hi", hi, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
